// File: rtl/sipo_pkg.sv
// Shared serialiser/deserialiser definitions: bit-order names, counter sizing
// and the output holding-register state encoding.
package serdes_pkg;

  localparam BIT_ORDER_MSB = "true";
  localparam BIT_ORDER_LSB = "false";

  // Counter width that still covers 0..w-1 for any w >= 2 (never zero bits).
  function automatic int unsigned cnt_width(input int unsigned w);
    if (w <= 2) begin
      return 1;
    end
    return $clog2(w);
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/sipo_if.sv
// Serial input and parallel valid/ready output of the sipo deserialiser.
interface sipo_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  i_sync;
  logic                  i_data_valid;
  logic                  i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  i_data_ready;
  logic                  o_busy;
  logic                  o_overrun;

  modport master (
    output i_sync, i_data_valid, i_data, i_data_ready,
    input  o_data, o_data_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_sync, i_data_valid, i_data, i_data_ready,
    output o_data, o_data_valid, o_busy, o_overrun
  );

endinterface

// File: rtl/sipo.sv
// Serial-in/parallel-out deserialiser with a one-word valid/ready holding
// register; all outputs are registered.
module sipo
  import serdes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter              DO_MSB_FIRST = "true"
) (
  input logic   i_clk,
  input logic   i_s_rst_n,
  sipo_if.slave bus
);

  localparam int unsigned     CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [DATA_WIDTH-1:0] sr_q;
  logic [DATA_WIDTH-1:0] sr_next;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  overrun_d;
  logic                  load;
  logic                  complete;
  out_state_t            state_q;
  out_state_t            state_d;

  generate
    if (DO_MSB_FIRST == BIT_ORDER_MSB) begin : g_msb
      assign sr_next = {sr_q[DATA_WIDTH-2:0], bus.i_data};
    end else begin : g_lsb
      assign sr_next = {bus.i_data, sr_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  // A sync-qualified bit always starts a new word, so it can never complete one.
  assign complete = bus.i_data_valid && !bus.i_sync && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_sync) begin
      cnt_d = bus.i_data_valid ? CNT_ONE : '0;
    end else if (bus.i_data_valid) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (bus.i_data_ready) begin
          if (complete) begin
            load = 1'b1;
          end else begin
            state_d = OUT_EMPTY;
          end
        end else if (complete) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_s_rst_n) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      state_q   <= OUT_EMPTY;
    end else begin
      if (bus.i_data_valid) begin
        sr_q <= sr_next;
      end
      if (load) begin
        data_q <= sr_next;
      end
      cnt_q     <= cnt_d;
      busy_q    <= (cnt_d != '0);
      overrun_q <= overrun_d;
      state_q   <= state_d;
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = (state_q == OUT_FULL);
  assign bus.o_busy       = busy_q;
  assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_sipo.sv
// Directed scoreboard bench for sipo: one MSB-first and one LSB-first instance.
module tb_sipo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   ovr_count = 0;
  logic [7:0] q_msb[$];
  logic [7:0] q_lsb[$];

  always #5 clk = ~clk;

  sipo_if #(.DATA_WIDTH(8)) bm ();
  sipo_if #(.DATA_WIDTH(8)) bl ();

  sipo #(.DATA_WIDTH(8), .DO_MSB_FIRST("true")) u_msb (
    .i_clk(clk), .i_s_rst_n(rst_n), .bus(bm)
  );
  sipo #(.DATA_WIDTH(8), .DO_MSB_FIRST("false")) u_lsb (
    .i_clk(clk), .i_s_rst_n(rst_n), .bus(bl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a word is consumed when valid & ready at the sample point.
  always @(negedge clk) begin
    if (rst_n && bm.o_data_valid && bm.i_data_ready) begin
      if (q_msb.size() == 0) begin
        check("msb_unexpected_word", bm.o_data, 32'hFFFF_FFFF);
      end else begin
        check("msb_word", bm.o_data, q_msb.pop_front());
      end
    end
    if (rst_n && bm.o_overrun) ovr_count++;
  end

  always @(negedge clk) begin
    if (rst_n && bl.o_data_valid && bl.i_data_ready) begin
      if (q_lsb.size() == 0) begin
        check("lsb_unexpected_word", bl.o_data, 32'hFFFF_FFFF);
      end else begin
        check("lsb_word", bl.o_data, q_lsb.pop_front());
      end
    end
  end

  task automatic drive_bit(input bit to_lsb, input logic b, input logic s);
    @(posedge clk); #1;
    bm.i_data_valid = !to_lsb; bm.i_data = b; bm.i_sync = s & !to_lsb;
    bl.i_data_valid = to_lsb;  bl.i_data = b; bl.i_sync = s & to_lsb;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bm.i_data_valid = 1'b0; bm.i_sync = 1'b0; bm.i_data = 1'b0;
    bl.i_data_valid = 1'b0; bl.i_sync = 1'b0; bl.i_data = 1'b0;
  endtask

  task automatic send_word(input bit to_lsb, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) drive_bit(to_lsb, w[i], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    bm.i_sync = 0; bm.i_data_valid = 0; bm.i_data = 0; bm.i_data_ready = 1;
    bl.i_sync = 0; bl.i_data_valid = 0; bl.i_data = 0; bl.i_data_ready = 1;

    // Reset state
    idle(); idle();
    @(negedge clk);
    check("rst_valid", bm.o_data_valid, 0);
    check("rst_data", bm.o_data, 0);
    check("rst_busy", bm.o_busy, 0);
    check("rst_overrun", bm.o_overrun, 0);
    check("rst_lsb_valid", bl.o_data_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: MSB-first, continuous stream, one-cycle valid pulse
    q_msb.push_back(8'h1E);
    send_word(0, 8'b0001_1110);
    @(negedge clk);
    check("t1_valid_before", bm.o_data_valid, 0);
    idle();
    @(negedge clk);
    check("t1_valid_after", bm.o_data_valid, 1);
    check("t1_data", bm.o_data, 8'h1E);
    check("t1_busy", bm.o_busy, 0);
    idle();
    @(negedge clk);
    check("t1_valid_drop", bm.o_data_valid, 0);

    // 2: LSB-first, continuous then with gaps and busy tracking
    q_lsb.push_back(8'h78);
    send_word(1, 8'b0001_1110);
    idle(); idle(); idle();
    q_lsb.push_back(8'h78);
    w = 8'b0001_1110;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(1, w[i], 1'b0);
      idle();
      @(negedge clk);
      check("t2_busy", bl.o_busy, (i != 0));
      repeat ($urandom_range(0, 2)) idle();
    end
    idle(); idle();
    check("t2_lsb_drained", q_lsb.size(), 0);

    // 3: overrun with holding register full
    bm.i_data_ready = 0;
    q_msb.push_back(8'hA5);
    send_word(0, 8'hA5);
    send_word(0, 8'h3C);
    idle();
    @(negedge clk);
    check("t3_overrun_pulse", bm.o_overrun, 1);
    check("t3_data_kept", bm.o_data, 8'hA5);
    check("t3_valid_held", bm.o_data_valid, 1);
    idle();
    @(negedge clk);
    check("t3_overrun_clear", bm.o_overrun, 0);
    check("t3_overrun_count", ovr_count, 1);
    @(posedge clk); #1 bm.i_data_ready = 1;
    idle();
    @(negedge clk);
    check("t3_valid_fall", bm.o_data_valid, 0);

    // 4: ready rises exactly on the completion cycle of the second word
    bm.i_data_ready = 0;
    q_msb.push_back(8'hA5);
    q_msb.push_back(8'h3C);
    send_word(0, 8'hA5);
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) drive_bit(0, w[i], 1'b0);
    drive_bit(0, w[0], 1'b0);
    bm.i_data_ready = 1;
    idle();
    @(negedge clk);
    check("t4_valid_stays", bm.o_data_valid, 1);
    check("t4_data_next", bm.o_data, 8'h3C);
    check("t4_no_overrun", bm.o_overrun, 0);
    idle();
    @(negedge clk);
    check("t4_valid_fall", bm.o_data_valid, 0);
    check("t4_overrun_count", ovr_count, 1);

    // 5: sync realigns after a partial word
    q_msb.push_back(8'hC3);
    drive_bit(0, 1, 0); drive_bit(0, 1, 0); drive_bit(0, 1, 0);
    w = 8'hC3;
    drive_bit(0, w[7], 1'b1);
    for (int i = 6; i >= 0; i--) drive_bit(0, w[i], 1'b0);
    idle(); idle(); idle();
    check("t5_drained", q_msb.size(), 0);

    // 6: reset mid-word
    drive_bit(0, 1, 0); drive_bit(0, 0, 0); drive_bit(0, 1, 0);
    drive_bit(0, 0, 0); drive_bit(0, 1, 0);
    idle();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("t6_rst_valid", bm.o_data_valid, 0);
    check("t6_rst_data", bm.o_data, 0);
    check("t6_rst_busy", bm.o_busy, 0);
    check("t6_rst_overrun", bm.o_overrun, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    q_msb.push_back(8'h81);
    send_word(0, 8'h81);
    idle(); idle(); idle();

    check("final_msb_queue", q_msb.size(), 0);
    check("final_lsb_queue", q_lsb.size(), 0);
    check("final_overrun_count", ovr_count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
